// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if
// Groups the game-control inputs and the obstacle/score outputs of the pipe
// scroller into one bundle. The master side (game logic or testbench) drives
// the controls and the random y source. The slave side (pipe_scroller)
// drives the pipe positions, score, speed, FSM state and the pass strobe.
//
// Signals
//   rand_y     : pseudo-random y source, sampled on respawn
//   start      : level, IDLE -> RUN
//   over       : level, game-over request, RUN -> FROZEN
//   restart    : pulse, FROZEN -> IDLE
//   pip_x/pip_y: pipe i coordinate in bits [i*COORD_W +: COORD_W]
//   score      : pipes passed (saturating)
//   speed      : pixels moved per movement tick
//   state      : 00 IDLE, 01 RUN, 10 FROZEN
//   pass_pulse : one-cycle strobe on every scoring tick
interface pipe_scroller_if #(
    parameter int NUM_PIPES = 3,
    parameter int COORD_W   = 12,
    parameter int SCORE_W   = 8
);
    logic [COORD_W-1:0]           rand_y;
    logic                         start;
    logic                         over;
    logic                         restart;
    logic [NUM_PIPES*COORD_W-1:0] pip_x;
    logic [NUM_PIPES*COORD_W-1:0] pip_y;
    logic [SCORE_W-1:0]           score;
    logic [3:0]                   speed;
    logic [1:0]                   state;
    logic                         pass_pulse;

    modport master (
        output rand_y, start, over, restart,
        input  pip_x, pip_y, score, speed, state, pass_pulse
    );

    modport slave (
        input  rand_y, start, over, restart,
        output pip_x, pip_y, score, speed, state, pass_pulse
    );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller
// Moves NUM_PIPES obstacle channels leftwards by 'speed' pixels once every
// TICK_DIV clock cycles while the game runs. A pipe that would reach or pass
// x = 0 respawns at X_RESPAWN with a clamped random gap centre, scores a
// point, and every SPEED_STEP points the speed rises by one up to SPEED_MAX.
//
// Ports
//   clk   : clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset, restores the initial layout
//   bus   : pipe_scroller_if slave modport (controls in, positions out)
module pipe_scroller #(
    parameter int NUM_PIPES  = 3,
    parameter int COORD_W    = 12,
    parameter int SCORE_W    = 8,
    parameter int TICK_DIV   = 1000000,
    parameter int X_START    = 1200,
    parameter int SPACING    = 500,
    parameter int X_RESPAWN  = 1560,
    parameter int Y_INIT     = 300,
    parameter int Y_MIN      = 150,
    parameter int Y_MAX      = 580,
    parameter int Y_ADJ      = 150,
    parameter int SPEED_INIT = 1,
    parameter int SPEED_MAX  = 8,
    parameter int SPEED_STEP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_scroller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    localparam int                 CNT_W     = $clog2(TICK_DIV);
    localparam int                 SUM_W     = SCORE_W + 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             st;
    logic [CNT_W-1:0]   tick_cnt;
    logic [COORD_W-1:0] x_q [NUM_PIPES];
    logic [COORD_W-1:0] y_q [NUM_PIPES];
    logic [SCORE_W-1:0] score_q;
    logic [3:0]         speed_q;
    logic               pass_q;

    logic                 tick;
    logic [NUM_PIPES-1:0] respawn;
    logic [3:0]           resp_cnt;
    logic [COORD_W-1:0]   y_new;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;
    logic                 speed_bump;
    logic [3:0]           speed_next;

    function automatic logic [COORD_W-1:0] init_x(input int i);
        return COORD_W'(X_START + i * SPACING);
    endfunction

    // Pull out-of-range random values back towards the playable band.
    function automatic logic [COORD_W-1:0] clamp_y(input logic [COORD_W-1:0] v);
        if (v < COORD_W'(Y_MIN)) begin
            return v + COORD_W'(Y_ADJ);
        end else if (v > COORD_W'(Y_MAX)) begin
            return v - COORD_W'(Y_ADJ);
        end else begin
            return v;
        end
    endfunction

    // Tick strobe fires on the last count of the divider while running.
    // A respawn is any pipe that could not move left by a full speed step
    // without reaching zero, which is what keeps x from underflowing.
    always_comb begin
        tick     = (st == ST_RUN) && (tick_cnt == CNT_W'(TICK_DIV - 1));
        respawn  = '0;
        resp_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            respawn[i] = (x_q[i] <= COORD_W'(speed_q));
            if (respawn[i]) begin
                resp_cnt = resp_cnt + 4'd1;
            end
        end
        y_new = clamp_y(bus.rand_y);
    end

    // Score saturates at its maximum. Speed rises once whenever the score
    // enters a new SPEED_STEP bucket, except once the score is already
    // pinned at its maximum.
    always_comb begin
        score_sum  = SUM_W'(score_q) + SUM_W'(resp_cnt);
        score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        speed_bump = (score_q != SCORE_MAX) &&
                     ((int'(score_next) / SPEED_STEP) != (int'(score_q) / SPEED_STEP));
        speed_next = (speed_bump && (speed_q < 4'(SPEED_MAX))) ? (speed_q + 4'd1) : speed_q;
    end

    // Game FSM with the pipe, score and speed registers. IDLE keeps the
    // initial layout loaded, so every entry to IDLE starts a fresh game.
    // In RUN an asserted 'over' takes priority over a coinciding tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            tick_cnt <= '0;
            score_q  <= '0;
            speed_q  <= 4'(SPEED_INIT);
            pass_q   <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i] <= init_x(i);
                y_q[i] <= COORD_W'(Y_INIT);
            end
        end else begin
            pass_q <= 1'b0;
            case (st)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    score_q  <= '0;
                    speed_q  <= 4'(SPEED_INIT);
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        x_q[i] <= init_x(i);
                        y_q[i] <= COORD_W'(Y_INIT);
                    end
                    if (bus.start && !bus.over) begin
                        st <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.over) begin
                        st <= ST_FROZEN;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            if (respawn[i]) begin
                                x_q[i] <= COORD_W'(X_RESPAWN);
                                y_q[i] <= y_new;
                            end else begin
                                x_q[i] <= x_q[i] - COORD_W'(speed_q);
                            end
                        end
                        if (resp_cnt != 4'd0) begin
                            score_q <= score_next;
                            speed_q <= speed_next;
                            pass_q  <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (bus.restart) begin
                        st       <= ST_IDLE;
                        tick_cnt <= '0;
                        score_q  <= '0;
                        speed_q  <= 4'(SPEED_INIT);
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            x_q[i] <= init_x(i);
                            y_q[i] <= COORD_W'(Y_INIT);
                        end
                    end
                end
                default: begin
                    st       <= ST_IDLE;
                    tick_cnt <= '0;
                    score_q  <= '0;
                    speed_q  <= 4'(SPEED_INIT);
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        x_q[i] <= init_x(i);
                        y_q[i] <= COORD_W'(Y_INIT);
                    end
                end
            endcase
        end
    end

    // Flatten the registered pipe arrays onto the packed output buses.
    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            bus.pip_x[i*COORD_W +: COORD_W] = x_q[i];
            bus.pip_y[i*COORD_W +: COORD_W] = y_q[i];
        end
    end

    assign bus.score      = score_q;
    assign bus.speed      = speed_q;
    assign bus.state      = st;
    assign bus.pass_pulse = pass_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller
// Scoreboard bench for pipe_scroller with NUM_PIPES=3, TICK_DIV=4,
// SPEED_STEP=2, SCORE_W=4. A tick-level model predicts each scoring tick and
// pushes the expected snapshot into a queue, and a monitor pops and compares
// it whenever the DUT raises pass_pulse. Directed checkpoints compare the
// hand-computed layout at reset, after respawns, on freeze and on restart.
module tb_pipe_scroller;

    localparam int NP = 3;
    localparam int CW = 12;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_scroller_if #(.NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(SW)) bus ();

    pipe_scroller #(
        .NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(SW), .TICK_DIV(4),
        .X_START(1200), .SPACING(500), .X_RESPAWN(1560), .Y_INIT(300),
        .Y_MIN(150), .Y_MAX(580), .Y_ADJ(150),
        .SPEED_INIT(1), .SPEED_MAX(8), .SPEED_STEP(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int score;
        int speed;
        int x0, x1, x2;
        int y0, y1, y2;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    int compares = 0;
    int fails = 0;

    int mx[NP];
    int my[NP];
    int mscore;
    int mspeed;
    int satPasses;

    int randTab[8] = '{50, 600, 333, 580, 150, 149, 581, 900};

    task automatic checkOutput(input string name, input int got, input int want);
        compares++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic o, input logic r, input int ry);
        bus.start   = s;
        bus.over    = o;
        bus.restart = r;
        bus.rand_y  = CW'(ry);
    endtask

    function automatic int clampModel(input int v);
        if (v < 150) return v + 150;
        if (v > 580) return v - 150;
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NP; i++) begin
            mx[i] = 1200 + 500 * i;
            my[i] = 300;
        end
        mscore = 0;
        mspeed = 1;
    endtask

    // One movement tick of the reference game, using the speed in force
    // before this tick. A scoring tick queues the expected visible state.
    task automatic modelTick(input int ry);
        int k;
        int ny;
        int old;
        bit crossed;
        exp_t e;
        k  = 0;
        ny = clampModel(ry);
        for (int i = 0; i < NP; i++) begin
            if (mx[i] <= mspeed) begin
                mx[i] = 1560;
                my[i] = ny;
                k++;
            end else begin
                mx[i] = mx[i] - mspeed;
            end
        end
        if (k > 0) begin
            old = mscore;
            crossed = 1'b0;
            if (old == 15) satPasses++;
            for (int s = old + 1; s <= old + k && s <= 15; s++) begin
                if (s % 2 == 0) crossed = 1'b1;
            end
            mscore = (old + k > 15) ? 15 : old + k;
            if (crossed && mspeed < 8) mspeed++;
            e.score = mscore;
            e.speed = mspeed;
            e.x0 = mx[0]; e.x1 = mx[1]; e.x2 = mx[2];
            e.y0 = my[0]; e.y1 = my[1]; e.y2 = my[2];
            expQ.push_back(e);
        end
    endtask

    function automatic int pipX(input int i);
        logic [NP*CW-1:0] v;
        v = bus.pip_x;
        return int'(v[i*CW +: CW]);
    endfunction

    function automatic int pipY(input int i);
        logic [NP*CW-1:0] v;
        v = bus.pip_y;
        return int'(v[i*CW +: CW]);
    endfunction

    task automatic checkModelState(input string tag, input int expState);
        checkOutput({tag, "_state"}, int'(bus.state), expState);
        checkOutput({tag, "_score"}, int'(bus.score), mscore);
        checkOutput({tag, "_speed"}, int'(bus.speed), mspeed);
        for (int i = 0; i < NP; i++) begin
            checkOutput($sformatf("%s_x%0d", tag, i), pipX(i), mx[i]);
            checkOutput($sformatf("%s_y%0d", tag, i), pipY(i), my[i]);
        end
    endtask

    // Called one step after a tick edge; waits for the next tick edge,
    // presenting ry to the DUT just before it.
    task automatic runTicks(input int n, input int ry);
        for (int t = 0; t < n; t++) begin
            repeat (4) @(negedge clk);
            bus.rand_y = CW'(ry);
            @(posedge clk);
            #1;
            modelTick(ry);
        end
    endtask

    task automatic runUntilScore(input int target, input int ry, input int maxTicks);
        int t;
        t = 0;
        while (mscore < target && t < maxTicks) begin
            runTicks(1, ry);
            t++;
        end
        checkOutput($sformatf("reach_score_%0d", target), mscore, target);
    endtask

    // Scoreboard monitor: every pass strobe consumes one queued prediction.
    always @(negedge clk) begin
        if (rst_n && bus.pass_pulse) begin
            if (expQ.size() == 0) begin
                compares++;
                fails++;
                $display("[TB] FAIL unexpected_pass: got pass_pulse 1, expected 0");
            end else begin
                monE = expQ.pop_front();
                checkOutput("pass_score", int'(bus.score), monE.score);
                checkOutput("pass_speed", int'(bus.speed), monE.speed);
                checkOutput("pass_x0", pipX(0), monE.x0);
                checkOutput("pass_x1", pipX(1), monE.x1);
                checkOutput("pass_x2", pipX(2), monE.x2);
                checkOutput("pass_y0", pipY(0), monE.y0);
                checkOutput("pass_y1", pipY(1), monE.y1);
                checkOutput("pass_y2", pipY(2), monE.y2);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        satPasses = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        modelReset();

        // Reset state
        repeat (3) @(negedge clk);
        checkModelState("reset", 0);
        checkOutput("reset_pass", int'(bus.pass_pulse), 0);
        rst_n = 1'b1;

        // Stays in IDLE without start; start with over held does nothing
        repeat (3) @(negedge clk);
        checkOutput("idle_hold_state", int'(bus.state), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        repeat (3) @(negedge clk);
        checkOutput("start_blocked_state", int'(bus.state), 0);

        // Start: first movement tick lands four edges after entering RUN
        applyStimulus(1'b1, 1'b0, 1'b0, 100);
        @(posedge clk);
        #1;
        checkModelState("run_entry", 1);
        runTicks(5, 100);
        checkOutput("tick5_x0", pipX(0), 1195);
        checkOutput("tick5_x1", pipX(1), 1695);
        checkOutput("tick5_x2", pipX(2), 2195);

        // First respawn of pipe 0 with rand_y=100 clamps up to 250
        runUntilScore(1, 100, 2000);
        checkOutput("resp0_x0", pipX(0), 1560);
        checkOutput("resp0_y0", pipY(0), 250);
        checkOutput("resp0_x1", pipX(1), 500);
        checkOutput("resp0_x2", pipX(2), 1000);
        checkOutput("resp0_score", int'(bus.score), 1);
        checkOutput("resp0_speed", int'(bus.speed), 1);

        // rand_y=700 clamps down to 550; score 2 raises speed to 2
        runUntilScore(2, 700, 2000);
        checkOutput("resp1_x1", pipX(1), 1560);
        checkOutput("resp1_y1", pipY(1), 550);
        checkOutput("resp1_x0", pipX(0), 1060);
        checkOutput("resp1_x2", pipX(2), 500);
        checkOutput("resp1_speed", int'(bus.speed), 2);

        // rand_y=400 is in band and passes unchanged
        runUntilScore(3, 400, 2000);
        checkOutput("resp2_x2", pipX(2), 1560);
        checkOutput("resp2_y2", pipY(2), 400);
        checkOutput("resp2_x0", pipX(0), 560);
        checkOutput("resp2_score", int'(bus.score), 3);

        // New speed moves pipes by 2 per tick
        runTicks(1, 400);
        checkOutput("speed2_x0", pipX(0), 558);
        checkOutput("speed2_x1", pipX(1), 1058);
        checkOutput("speed2_x2", pipX(2), 1558);

        // Play on until score saturates, then see further passes hold it
        t = 0;
        while (!(mscore == 15 && satPasses >= 2) && t < 8000) begin
            runTicks(1, randTab[t % 8]);
            t++;
        end
        checkOutput("saturate_passes", satPasses, 2);
        checkOutput("sat_score", int'(bus.score), 15);
        checkOutput("sat_speed", int'(bus.speed), 8);
        checkModelState("sat", 1);

        // over on a tick edge: freeze wins, nothing moves
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 100);
        @(posedge clk);
        #1;
        checkModelState("freeze", 2);
        repeat (9) @(negedge clk);
        checkModelState("frozen_hold", 2);

        // restart returns to IDLE with the initial layout
        applyStimulus(1'b0, 1'b0, 1'b1, 100);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 100);
        modelReset();
        checkModelState("restart", 0);

        // Run again, then assert reset mid-cycle with no clock edge
        applyStimulus(1'b1, 1'b0, 1'b0, 400);
        @(posedge clk);
        #1;
        runTicks(3, 400);
        checkOutput("rerun_x0", pipX(0), 1197);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkModelState("async_reset", 0);
        checkOutput("async_reset_pass", int'(bus.pass_pulse), 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_reset_idle", int'(bus.state), 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 Parameter NUM_PIPES, default 3: number of obstacle channels, range 1..8.
REQ-002 Parameter COORD_W, default 12: coordinate width in bits.
REQ-003 Parameter SCORE_W, default 8: score counter width in bits.
REQ-004 Parameter TICK_DIV, default 1000000: clk cycles per movement tick, at least 2.
REQ-005 Parameter X_START, default 1200: initial x of pipe 0.
REQ-006 Parameter SPACING, default 500: initial x step between pipe i and pipe i+1.
REQ-007 Parameter X_RESPAWN, default 1560: x loaded on respawn.
REQ-008 Parameter Y_INIT, default 300: initial y of every pipe.
REQ-009 Parameter Y_MIN / Y_MAX / Y_ADJ, defaults 150 / 580 / 150: gap-centre clamp bounds and the adjustment amount.
REQ-010 Parameter SPEED_INIT / SPEED_MAX / SPEED_STEP, defaults 1 / 8 / 4: initial speed, speed ceiling, and points per speed increment.
REQ-011 clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-012 rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-013 rand_y, input, COORD_W bits: pseudo-random y source, sampled at respawn.
REQ-014 start, input, 1 bit: level; moves IDLE to RUN.
REQ-015 over, input, 1 bit: level; game-over request, moves RUN to FROZEN.
REQ-016 restart, input, 1 bit: pulse; moves FROZEN to IDLE and reinitialises.
REQ-017 pip_x, output, NUM_PIPES*COORD_W bits: pipe i x in bits [i*COORD_W +: COORD_W].
REQ-018 pip_y, output, NUM_PIPES*COORD_W bits: pipe i y, same packing as pip_x.
REQ-019 score, output, SCORE_W bits: pipes passed.
REQ-020 speed, output, 4 bits: current pixels per tick.
REQ-021 state, output, 2 bits: 00 = IDLE, 01 = RUN, 10 = FROZEN.
REQ-022 pass_pulse, output, 1 bit: one-cycle strobe on each scoring tick.

Function
REQ-023 FSM states are IDLE, RUN and FROZEN; encoding 11 is unreachable and SHALL return to IDLE on the next cycle.
REQ-024 Transitions: IDLE to RUN when start=1 and over=0; RUN to FROZEN when over=1; FROZEN to IDLE when restart=1; start and restart have no effect in any other state.
REQ-025 Entry to IDLE SHALL load pipe i with x = X_START + i*SPACING and y = Y_INIT, and set score = 0 and speed = SPEED_INIT.
REQ-026 Tick counter counts 0..TICK_DIV-1 in RUN only; the tick strobe is internal, one cycle, on count = TICK_DIV-1, after which the count wraps to 0.
REQ-027 The tick counter clears to 0 in IDLE and holds its value in FROZEN.
REQ-028 On each tick in RUN, every pipe with x > speed SHALL update to x - speed.
REQ-029 On the same tick, every pipe with x <= speed SHALL respawn at x = X_RESPAWN, with y = clamp(rand_y) sampled that cycle; x never underflows.
REQ-030 clamp(v): v < Y_MIN gives v + Y_ADJ; v > Y_MAX gives v - Y_ADJ; otherwise v; the result is truncated to COORD_W.
REQ-031 Simultaneous respawns SHALL all take place on that tick, and all of them receive the same clamped y.
REQ-032 On a tick with k >= 1 respawns, score increases by k, saturating at 2^SCORE_W - 1, and pass_pulse = 1 for that cycle; otherwise pass_pulse = 0.
REQ-033 Speed SHALL increment by 1, saturating at SPEED_MAX, whenever the updated score crosses a multiple of SPEED_STEP; at most one increment per tick.
REQ-034 The new speed takes effect from the next tick.
REQ-035 Once score has saturated, speed SHALL not change.
REQ-036 If over=1 coincides with a tick in RUN, the freeze wins: no movement, no score change, and state becomes FROZEN.
REQ-037 In FROZEN, all positions, score and speed hold their values.
REQ-038 All outputs are registered, and changes appear one cycle after the causing edge.

Reset
REQ-039 rst_n=0 SHALL immediately force: state IDLE, the REQ-025 initial values, tick counter 0, pass_pulse 0.
REQ-040 Reset asserted mid-RUN or mid-FROZEN SHALL discard all progress.
REQ-041 After release, the block stays in IDLE until start.

Verification (NUM_PIPES=3, TICK_DIV=4, SPEED_STEP=2, SCORE_W=4)
REQ-042 Release reset, start=1 -> pipes at x 1200/1700/2200 with y=300, then every 4 cycles each x drops by 1.
REQ-043 Pipe 0 at x=1, tick with rand_y=100 -> pipe 0 reloads at x=1560 with y=250, score 0 to 1, pass_pulse high for 1 cycle.
REQ-044 rand_y=700 at respawn -> y=550; rand_y=400 -> y=400.
REQ-045 Score reaches 2 -> speed becomes 2 and x steps by 2; force score to 15 and respawn -> score stays 15, speed unchanged.
REQ-046 over=1 on a tick cycle -> positions and score frozen; restart -> IDLE initial values; rst_n low mid-RUN -> initial values the same cycle, no clk edge needed.
